// File: rtl/alu_rr_sched_if.sv
// Request/response and shared-ALU signals of alu_rr_sched.
// master = requesters plus the external ALU; slave = the scheduler.
interface alu_rr_sched_if #(parameter int BUS_WIDTH = 8);
    logic [1:0]             req_valid;
    logic [1:0]             req_ready;
    logic [2*BUS_WIDTH-1:0] req_a;
    logic [2*BUS_WIDTH-1:0] req_b;
    logic [1:0]             req_cin;
    logic [7:0]             req_opcode;
    logic [1:0]             resp_valid;
    logic [1:0]             resp_ready;
    logic [BUS_WIDTH-1:0]   resp_y;
    logic [4:0]             resp_flags;
    logic                   busy;
    logic [BUS_WIDTH-1:0]   alu_a;
    logic [BUS_WIDTH-1:0]   alu_b;
    logic                   alu_cin;
    logic [3:0]             alu_opcode;
    logic [BUS_WIDTH-1:0]   alu_y;
    logic                   alu_cout;
    logic                   alu_borrow;
    logic                   alu_invalid_op;
    logic                   alu_zero;
    logic                   alu_parity;

    modport master (
        output req_valid, req_a, req_b, req_cin, req_opcode, resp_ready,
               alu_y, alu_cout, alu_borrow, alu_invalid_op, alu_zero, alu_parity,
        input  req_ready, resp_valid, resp_y, resp_flags, busy,
               alu_a, alu_b, alu_cin, alu_opcode
    );

    modport slave (
        input  req_valid, req_a, req_b, req_cin, req_opcode, resp_ready,
               alu_y, alu_cout, alu_borrow, alu_invalid_op, alu_zero, alu_parity,
        output req_ready, resp_valid, resp_y, resp_flags, busy,
               alu_a, alu_b, alu_cin, alu_opcode
    );
endinterface

// File: rtl/alu_rr_sched.sv
// Round-robin arbiter sharing one combinational ALU between two requesters;
// one operation in flight: IDLE (accept) -> EXEC (ALU evaluates) -> RESP (return).
module alu_rr_sched #(
    parameter int BUS_WIDTH = 8
) (
    input logic           clk,
    input logic           rst,
    alu_rr_sched_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

    state_e               state_q, state_d;
    logic                 last_q, last_d;
    logic                 grant_q, grant_d;
    logic [BUS_WIDTH-1:0] a_q, a_d, b_q, b_d, y_q, y_d;
    logic                 cin_q, cin_d;
    logic [3:0]           op_q, op_d;
    logic [4:0]           flags_q, flags_d;
    logic                 win;
    logic [1:0]           rdy, rvld;
    logic                 bsy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            grant_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            op_q    <= '0;
            y_q     <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cin_q   <= cin_d;
            op_q    <= op_d;
            y_q     <= y_d;
            flags_q <= flags_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        grant_d = grant_q;
        a_d     = a_q;
        b_d     = b_q;
        cin_d   = cin_q;
        op_d    = op_q;
        y_d     = y_q;
        flags_d = flags_q;
        rdy     = 2'b00;
        rvld    = 2'b00;
        bsy     = 1'b0;
        // Requester 1 wins when alone, or when both contend and 0 was served last.
        win     = bus.req_valid[1] & (~bus.req_valid[0] | ~last_q);
        case (state_q)
            IDLE: begin
                // Reset masks ready so a coincident handshake never appears.
                if (!rst && (bus.req_valid != 2'b00)) begin
                    rdy     = win ? 2'b10 : 2'b01;
                    grant_d = win;
                    last_d  = win;
                    a_d     = win ? bus.req_a[2*BUS_WIDTH-1:BUS_WIDTH] : bus.req_a[BUS_WIDTH-1:0];
                    b_d     = win ? bus.req_b[2*BUS_WIDTH-1:BUS_WIDTH] : bus.req_b[BUS_WIDTH-1:0];
                    cin_d   = win ? bus.req_cin[1] : bus.req_cin[0];
                    op_d    = win ? bus.req_opcode[7:4] : bus.req_opcode[3:0];
                    state_d = EXEC;
                end
            end
            EXEC: begin
                bsy     = 1'b1;
                y_d     = bus.alu_y;
                flags_d = {bus.alu_invalid_op, bus.alu_parity, bus.alu_zero,
                           bus.alu_borrow, bus.alu_cout};
                state_d = RESP;
            end
            RESP: begin
                bsy  = 1'b1;
                rvld = grant_q ? 2'b10 : 2'b01;
                if (bus.resp_ready[grant_q]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.req_ready  = rdy;
    assign bus.resp_valid = rvld;
    assign bus.busy       = bsy;
    assign bus.resp_y     = y_q;
    assign bus.resp_flags = flags_q;
    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign bus.alu_cin    = cin_q;
    assign bus.alu_opcode = op_q;
endmodule

// File: doc/alu_rr_sched.md
Name: alu_rr_sched

Overview:
- Round-robin scheduler that shares one combinational ALU instance between two requesters.
- Each requester submits an operation (a, b, cin, opcode) on a valid/ready handshake.
- The scheduler grants one requester, registers its operands onto the ALU input bus and captures the ALU outputs one cycle later.
- It returns the result on a per-requester valid/ready response channel. One operation is in flight at a time.

Parameters:
- BUS_WIDTH, 8: operand/result width; must match the shared ALU.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req_valid  input  2  bit i = requester i presents an operation
- req_ready  output  2  bit i = operation of requester i accepted this cycle
- req_a  input  2*BUS_WIDTH  requester i operand A at [i*BUS_WIDTH +: BUS_WIDTH]
- req_b  input  2*BUS_WIDTH  requester i operand B, same packing
- req_cin  input  2  requester i carry-in
- req_opcode  input  8  requester i opcode at [i*4 +: 4]
- resp_valid  output  2  bit i = result for requester i available
- resp_ready  input  2  bit i = requester i consumes result
- resp_y  output  BUS_WIDTH  result, shared; meaningful only while a resp_valid bit is set
- resp_flags  output  5  {invalid_op, parity, zero, borrow, cout} captured from ALU
- busy  output  1  high in EXEC and RESP
- alu_a, alu_b  output  BUS_WIDTH each  registered ALU operands
- alu_cin  output  1  registered ALU carry-in
- alu_opcode  output  4  registered ALU opcode (encodings 1..9 valid, others flag invalid)
- alu_y  input  BUS_WIDTH  ALU result
- alu_cout, alu_borrow, alu_invalid_op, alu_zero, alu_parity  input  1 each  ALU flags

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state=IDLE; req_ready=0; resp_valid=0; resp_y=0; resp_flags=0; busy=0; alu_a/alu_b/alu_cin/alu_opcode=0; last_grant=1, so requester 0 wins the first contest.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - req_ready is combinational. Only the winner's bit is 1, and only if its req_valid is 1.
  - Winner: the sole valid requester; if both are valid, the requester != last_grant.
  - On handshake: latch winner's a/b/cin/opcode into alu_* registers, record grant index, set last_grant=winner, go to EXEC.
  - No valid request: stay in IDLE; alu_* registers hold.
- EXEC (exactly 1 cycle): the ALU evaluates the registered inputs. At the clock edge, capture alu_y into resp_y and the five flags into resp_flags, then go to RESP.
- RESP:
  - resp_valid[grant]=1, the other bit 0. resp_y/resp_flags held stable.
  - req_ready=0 for both requesters.
  - On resp_ready[grant]=1: go to IDLE. resp_valid drops next cycle.
  - resp_ready of the non-granted requester is ignored.
- Latency: request handshake at cycle T; resp_valid high from T+2. Minimum initiation interval 3 cycles per operation.
- No new acceptance in the same cycle as a response handshake. The next accept is earliest one cycle later, in IDLE.
- Requester inputs are sampled only at the handshake. Changes after acceptance do not affect the in-flight op.
- Invalid opcode: forwarded to the ALU unchanged. The response returns with invalid_op=1 and resp_y=0 (zero=1). No error state in the scheduler.
- Fairness: under continuous contention, grants strictly alternate 0,1,0,1.
- Reset mid-operation, in any state: next cycle is IDLE with all reset values. The pending result is discarded with no response.
- Simultaneous rst and any handshake: reset wins.

Test Plan:
- Single op, requester 0 only, ADD (1), a=200, b=100 -> req_ready[0]=1 at T; resp_valid[0]=1 at T+2; resp_y=44, flags cout=1, zero=0, parity=1.
- Both requesters continuously valid, resp_ready=11 -> accepted grant sequence 0,1,0,1; one accept every 3 cycles; each response carries its own requester's result.
- Backpressure: requester 1 SUB (3), a=5, b=7, resp_ready[1]=0 for 5 cycles -> resp_valid[1] held high, resp_y=254 and borrow=1 stable; req_ready=00 throughout; completes the cycle after resp_ready[1]=1.
- Opcode 0 from requester 0 -> resp_flags invalid_op=1, zero=1, parity=0, resp_y=0; scheduler returns to IDLE normally.
- rst pulsed in the EXEC cycle -> next cycle resp_valid=00, busy=0, alu_* = 0; subsequent simultaneous requests grant requester 0 first.
